// File: rtl/avalon_protocol_monitor_pkg.sv
// Shared types for the Avalon-MM protocol monitor: bus modes, error codes, burst FSM states.
// No logic here beyond a priority encoder used to pick the reported first error.
// Error codes double as bit indices into the err_pulse / err_sticky vectors.
package avalon_mon_pkg;

  typedef enum logic [2:0] {
    MODE_WAITREQ    = 3'd0,
    MODE_FIXED_WAIT = 3'd1,
    MODE_PIPE_VAR   = 3'd2,
    MODE_PIPE_FIXED = 3'd3,
    MODE_BURST      = 3'd4
  } avalon_mode_e;

  typedef enum logic [3:0] {
    ERR_NONE             = 4'd0,
    ERR_RW_BOTH          = 4'd1,
    ERR_STALL_UNSTABLE   = 4'd2,
    ERR_FIXED_HOLD       = 4'd3,
    ERR_RDV_UNEXPECTED   = 4'd4,
    ERR_OVERFLOW         = 4'd5,
    ERR_FIXED_LATENCY    = 4'd6,
    ERR_BURST_ADDR       = 4'd7,
    ERR_BURST_INTERLEAVE = 4'd8,
    ERR_BURSTCOUNT_ZERO  = 4'd9,
    ERR_BBT              = 4'd10
  } err_code_e;

  // Bit 0 (ERR_NONE) exists only so codes index the vector directly; it never fires.
  localparam int NB_ERR = 11;

  typedef enum logic {
    BURST_IDLE   = 1'b0,
    BURST_ACTIVE = 1'b1
  } burst_state_e;

  // Lowest set error code wins when several fire in the same cycle.
  function automatic err_code_e first_code(input logic [NB_ERR-1:0] v);
    err_code_e code;
    code = ERR_NONE;
    for (int i = NB_ERR - 1; i >= 1; i--) begin
      if (v[i]) code = err_code_e'(4'(i));
    end
    return code;
  endfunction

endpackage

// File: rtl/avalon_protocol_monitor_if.sv
// Avalon-MM link signals between one master and one slave, plus a passive tap view.
// Pure wiring, no latency.
// waitrequest / readdatavalid carry the slave-side flow control.
interface avalon_mon_if #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8
);
  localparam int DW = 8 * NBDATABYTES;

  logic [NBADDRBITS-1:0]  address;
  logic [NBDATABYTES-1:0] byteenable;
  logic [DW-1:0]          readdata;
  logic [DW-1:0]          writedata;
  logic                   read;
  logic                   write;
  logic                   waitrequest;
  logic                   readdatavalid;
  logic [7:0]             burstcount;
  logic                   beginbursttransfer;

  modport master (
    output address, byteenable, writedata, read, write, burstcount, beginbursttransfer,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write, burstcount, beginbursttransfer,
    output readdata, waitrequest, readdatavalid
  );

  // Observer view: every signal is an input, the monitor never drives the link.
  modport mon (
    input address, byteenable, readdata, writedata, read, write,
          waitrequest, readdatavalid, burstcount, beginbursttransfer
  );

endinterface

// File: rtl/avalon_protocol_monitor_latency_sr.sv
// Fixed-latency read checker: delays read accepts by FIXEDDELAY cycles and compares to readdatavalid.
// mismatch is combinational from the current readdatavalid and the shift register tap.
// Passive, never stalls anything.
module avalon_mon_latency_sr #(
  parameter int FIXEDDELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_accept,
  input  logic readdatavalid,
  output logic mismatch
);

  logic [FIXEDDELAY-1:0] sr;

  // Bit 0 holds the accept from the previous cycle; the top bit is when data is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | FIXEDDELAY'(rd_accept);
  end

  assign mismatch = readdatavalid != sr[FIXEDDELAY-1];

endmodule

// File: rtl/avalon_protocol_monitor.sv
// Passive Avalon-MM protocol checker with error pulses, sticky flags, first-error capture and pending-read tracking.
// Errors appear on err_pulse one cycle after the offending clock edge; status outputs are all registered.
// Never backpressures: observes waitrequest/readdatavalid only.
module avalon_protocol_monitor
  import avalon_mon_pkg::*;
#(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WRITEDELAY  = 2,
  parameter int READDELAY   = 1,
  parameter int FIXEDDELAY  = 2,
  parameter int MAXPENDING  = 8,
  localparam int PW = $clog2(MAXPENDING * 256 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  avalon_mon_if.mon         bus,
  input  logic              clear,
  output logic [NB_ERR-1:0] err_pulse,
  output logic [NB_ERR-1:0] err_sticky,
  output logic [3:0]        first_err,
  output logic [31:0]       first_err_cycle,
  output logic [PW-1:0]     pending
);

  localparam int DW = 8 * NBDATABYTES;
  localparam bit M_FIXED = (AVALONMODE == int'(MODE_FIXED_WAIT));
  localparam bit M_STALL = !M_FIXED;
  localparam bit M_PEND  = (AVALONMODE >= int'(MODE_PIPE_VAR));
  localparam bit M_BURST = (AVALONMODE == int'(MODE_BURST));
  // In burst mode each outstanding command may carry up to 256 beats.
  localparam int LIMIT   = M_BURST ? MAXPENDING * 256 : MAXPENDING;

  logic unused_readdata;
  assign unused_readdata = ^bus.readdata;

  logic cmd, rd_acc, wr_acc;
  assign cmd    = bus.read | bus.write;
  assign rd_acc = bus.read & ~bus.waitrequest;
  assign wr_acc = bus.write & ~bus.waitrequest;

  // ---------------- previous-cycle command snapshot ----------------
  logic [NBADDRBITS-1:0]  addr_q;
  logic [NBDATABYTES-1:0] be_q;
  logic [DW-1:0]          wd_q;
  logic                   rd_q, wr_q, stall_q;
  logic [7:0]             bc_q;

  // Capture the command as seen this cycle so stability can be checked next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bc_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      addr_q  <= bus.address;
      be_q    <= bus.byteenable;
      wd_q    <= bus.writedata;
      rd_q    <= bus.read;
      wr_q    <= bus.write;
      bc_q    <= bus.burstcount;
      stall_q <= cmd & bus.waitrequest;
    end
  end

  logic same_cmd, stall_err;
  assign same_cmd = (bus.address == addr_q) && (bus.byteenable == be_q) &&
                    (bus.read == rd_q) && (bus.write == wr_q) &&
                    (!wr_q || bus.writedata == wd_q) &&
                    (!M_BURST || bus.burstcount == bc_q);
  // Dropping the command entirely also shows up as read/write mismatch.
  assign stall_err = stall_q && !(cmd && same_cmd);

  // ---------------- fixed-wait hold counters ----------------
  logic [7:0] rd_hold, wr_hold;
  logic       rd_hold_err, wr_hold_err;
  assign rd_hold_err = (rd_hold != 8'd0) &&
                       (!bus.read || bus.address != addr_q || bus.byteenable != be_q);
  assign wr_hold_err = (wr_hold != 8'd0) &&
                       (!bus.write || bus.address != addr_q || bus.byteenable != be_q ||
                        bus.writedata != wd_q);

  // Load on the rising edge of read/write, count down while held, abandon on a violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_hold <= '0;
      wr_hold <= '0;
    end else begin
      if (rd_hold_err)            rd_hold <= '0;
      else if (rd_hold != 8'd0)   rd_hold <= rd_hold - 8'd1;
      else if (bus.read && !rd_q) rd_hold <= 8'(READDELAY);

      if (wr_hold_err)             wr_hold <= '0;
      else if (wr_hold != 8'd0)    wr_hold <= wr_hold - 8'd1;
      else if (bus.write && !wr_q) wr_hold <= 8'(WRITEDELAY);
    end
  end

  // ---------------- outstanding read beats ----------------
  logic [PW-1:0] pend_q;
  logic [31:0]   pend_inc, pend_sum;
  logic          rdv_unexp, pend_ovf;

  assign pend_inc  = rd_acc ? (M_BURST ? 32'(bus.burstcount) : 32'd1) : 32'd0;
  assign rdv_unexp = bus.readdatavalid && (pend_q == '0);
  assign pend_sum  = 32'(pend_q) + pend_inc - 32'(bus.readdatavalid && !rdv_unexp);
  assign pend_ovf  = pend_sum > 32'(LIMIT);

  // Net update of accepted beats and returned data; saturate at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pend_q <= '0;
    else if (!M_PEND)  pend_q <= '0;
    else if (pend_ovf) pend_q <= PW'(LIMIT);
    else               pend_q <= pend_sum[PW-1:0];
  end

  assign pending = pend_q;

  // ---------------- fixed-latency read check ----------------
  logic lat_err;
  generate
    if (AVALONMODE == int'(MODE_PIPE_FIXED) && FIXEDDELAY >= 1) begin : g_lat
      avalon_mon_latency_sr #(.FIXEDDELAY(FIXEDDELAY)) u_lat (
        .clk           (clk),
        .rst           (rst),
        .rd_accept     (rd_acc),
        .readdatavalid (bus.readdatavalid),
        .mismatch      (lat_err)
      );
    end else begin : g_no_lat
      assign lat_err = 1'b0;
    end
  endgenerate

  // ---------------- burst write FSM ----------------
  burst_state_e          bst_q, bst_d;
  logic [7:0]            left_q, left_d, bbc_q, bbc_d;
  logic [NBADDRBITS-1:0] baddr_q, baddr_d;
  logic                  burst_addr_err, interleave_err, bbt_exp;

  // Burst state register; held idle outside burst mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst_q   <= BURST_IDLE;
      left_q  <= '0;
      bbc_q   <= '0;
      baddr_q <= '0;
    end else begin
      bst_q   <= M_BURST ? bst_d : BURST_IDLE;
      left_q  <= left_d;
      bbc_q   <= bbc_d;
      baddr_q <= baddr_d;
    end
  end

  // Track remaining write beats and flag address/count drift or reads inside a burst.
  always_comb begin
    bst_d          = bst_q;
    left_d         = left_q;
    bbc_d          = bbc_q;
    baddr_d        = baddr_q;
    burst_addr_err = 1'b0;
    interleave_err = 1'b0;
    case (bst_q)
      BURST_IDLE: begin
        if (wr_acc && bus.burstcount > 8'd1) begin
          bst_d   = BURST_ACTIVE;
          left_d  = bus.burstcount - 8'd1;
          bbc_d   = bus.burstcount;
          baddr_d = bus.address;
        end
      end
      BURST_ACTIVE: begin
        burst_addr_err = bus.write && (bus.address != baddr_q || bus.burstcount != bbc_q);
        interleave_err = bus.read;
        if (wr_acc) begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) bst_d = BURST_IDLE;
        end
      end
      default: bst_d = BURST_IDLE;
    endcase
  end

  // A new command (not a stalled continuation) outside a burst must carry the marker.
  assign bbt_exp = cmd && !stall_q && (bst_q == BURST_IDLE);

  // ---------------- error collection ----------------
  logic [NB_ERR-1:0] err_raw;

  // Gather every check, masking those that do not apply to this mode.
  always_comb begin
    err_raw                       = '0;
    err_raw[ERR_RW_BOTH]          = bus.read & bus.write;
    err_raw[ERR_STALL_UNSTABLE]   = M_STALL & stall_err;
    err_raw[ERR_FIXED_HOLD]       = M_FIXED & (rd_hold_err | wr_hold_err);
    err_raw[ERR_RDV_UNEXPECTED]   = M_PEND & rdv_unexp;
    err_raw[ERR_OVERFLOW]         = M_PEND & pend_ovf;
    err_raw[ERR_FIXED_LATENCY]    = lat_err;
    err_raw[ERR_BURST_ADDR]       = M_BURST & burst_addr_err;
    err_raw[ERR_BURST_INTERLEAVE] = M_BURST & interleave_err;
    err_raw[ERR_BURSTCOUNT_ZERO]  = M_BURST & (rd_acc | wr_acc) & (bus.burstcount == 8'd0);
    err_raw[ERR_BBT]              = M_BURST & (bus.beginbursttransfer != bbt_exp);
  end

  logic [31:0] cyc_q, cyc_next;
  err_code_e   first_err_q;
  assign cyc_next = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  // Status registers: pulses every cycle, sticky/first-error until clear; clear beats a same-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q           <= '0;
      err_pulse       <= '0;
      err_sticky      <= '0;
      first_err_q     <= ERR_NONE;
      first_err_cycle <= '0;
    end else begin
      cyc_q     <= cyc_next;
      err_pulse <= err_raw;
      if (clear) begin
        err_sticky      <= '0;
        first_err_q     <= ERR_NONE;
        first_err_cycle <= '0;
      end else begin
        err_sticky <= err_sticky | err_raw;
        if (first_err_q == ERR_NONE && err_raw != '0) begin
          first_err_q     <= first_code(err_raw);
          first_err_cycle <= cyc_next;
        end
      end
    end
  end

  assign first_err = first_err_q;

endmodule

// File: tb/tb_avalon_protocol_monitor.sv
// Directed bench: one monitor instance per mode (0..4) on a shared clock/reset.
// Inputs are driven right after a rising edge, outputs sampled 1 time unit after the next one.
// Expected values are hand-computed constants or the bench's own cycle count.
module tb_avalon_protocol_monitor;
  import avalon_mon_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   checks   = 0;
  int   failures = 0;
  int   tcyc     = 0;

  always #5 clk = ~clk;

  avalon_mon_if if0 ();
  avalon_mon_if if1 ();
  avalon_mon_if if2 ();
  avalon_mon_if if3 ();
  avalon_mon_if if4 ();

  logic [NB_ERR-1:0] ep0, es0, ep1, es1, ep2, es2, ep3, es3, ep4, es4;
  logic [3:0]        fe0, fe1, fe2, fe3, fe4;
  logic [31:0]       fc0, fc1, fc2, fc3, fc4;
  logic [11:0]       pd0, pd1, pd2, pd3, pd4;

  avalon_protocol_monitor #(.AVALONMODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0), .clear(clear),
    .err_pulse(ep0), .err_sticky(es0), .first_err(fe0), .first_err_cycle(fc0), .pending(pd0));
  avalon_protocol_monitor #(.AVALONMODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .clear(clear),
    .err_pulse(ep1), .err_sticky(es1), .first_err(fe1), .first_err_cycle(fc1), .pending(pd1));
  avalon_protocol_monitor #(.AVALONMODE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2), .clear(clear),
    .err_pulse(ep2), .err_sticky(es2), .first_err(fe2), .first_err_cycle(fc2), .pending(pd2));
  avalon_protocol_monitor #(.AVALONMODE(3)) dut3 (.clk(clk), .rst(rst), .bus(if3), .clear(clear),
    .err_pulse(ep3), .err_sticky(es3), .first_err(fe3), .first_err_cycle(fc3), .pending(pd3));
  avalon_protocol_monitor #(.AVALONMODE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4), .clear(clear),
    .err_pulse(ep4), .err_sticky(es4), .first_err(fe4), .first_err_cycle(fc4), .pending(pd4));

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    {if0.read, if0.write, if0.waitrequest, if0.readdatavalid, if0.beginbursttransfer} = '0;
    {if1.read, if1.write, if1.waitrequest, if1.readdatavalid, if1.beginbursttransfer} = '0;
    {if2.read, if2.write, if2.waitrequest, if2.readdatavalid, if2.beginbursttransfer} = '0;
    {if3.read, if3.write, if3.waitrequest, if3.readdatavalid, if3.beginbursttransfer} = '0;
    {if4.read, if4.write, if4.waitrequest, if4.readdatavalid, if4.beginbursttransfer} = '0;
    if0.address = '0; if0.byteenable = 2'b11; if0.writedata = '0; if0.readdata = '0; if0.burstcount = 8'd1;
    if1.address = '0; if1.byteenable = 2'b11; if1.writedata = '0; if1.readdata = '0; if1.burstcount = 8'd1;
    if2.address = '0; if2.byteenable = 2'b11; if2.writedata = '0; if2.readdata = '0; if2.burstcount = 8'd1;
    if3.address = '0; if3.byteenable = 2'b11; if3.writedata = '0; if3.readdata = '0; if3.burstcount = 8'd1;
    if4.address = '0; if4.byteenable = 2'b11; if4.writedata = '0; if4.readdata = '0; if4.burstcount = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulse0", 32'(ep0), 32'h0);
    chk("reset_sticky4", 32'(es4), 32'h0);
    chk("reset_first_err0", 32'(fe0), 32'(ERR_NONE));
    chk("reset_first_cycle0", fc0, 32'h0);
    chk("reset_pending4", 32'(pd4), 32'h0);
    rst  = 1'b0;
    tcyc = 0;
    tick();

    // T1 mode 0: address changes while stalled
    if0.read = 1'b1; if0.address = 8'h10; if0.waitrequest = 1'b1;
    tick();
    chk("t1_first_stall_clean", 32'(ep0), 32'h0);
    if0.address = 8'h11;
    tick();
    chk("t1_stall_unstable", 32'(ep0), 32'h4);
    chk("t1_first_err", 32'(fe0), 32'(ERR_STALL_UNSTABLE));
    chk("t1_first_err_cycle", fc0, 32'(tcyc));
    tick();
    chk("t1_held_stable", 32'(ep0), 32'h0);
    if0.waitrequest = 1'b0;
    tick();
    chk("t1_accept_clean", 32'(ep0), 32'h0);
    if0.read = 1'b0;
    tick();
    chk("t1_sticky", 32'(es0), 32'h4);

    // Mode 1: read held long enough, read dropped early, write data changed inside hold
    if1.read = 1'b1; if1.address = 8'h30;
    tick();
    tick();
    chk("m1_read_hold_clean", 32'(ep1), 32'h0);
    if1.read = 1'b0;
    tick();
    if1.read = 1'b1;
    tick();
    if1.read = 1'b0;
    tick();
    chk("m1_read_dropped", 32'(ep1), 32'h8);
    tick();
    if1.write = 1'b1; if1.writedata = 16'hAAAA;
    tick();
    tick();
    chk("m1_write_hold_first", 32'(ep1), 32'h0);
    if1.writedata = 16'h5555;
    tick();
    chk("m1_write_data_changed", 32'(ep1), 32'h8);
    if1.write = 1'b0;
    tick();

    // T2 mode 2: pending counting, unexpected readdatavalid, overflow
    if2.read = 1'b1;
    repeat (4) tick();
    chk("t2_pending4", 32'(pd2), 32'd4);
    if2.read = 1'b0; if2.readdatavalid = 1'b1;
    repeat (2) tick();
    chk("t2_pending2", 32'(pd2), 32'd2);
    repeat (2) tick();
    chk("t2_pending0", 32'(pd2), 32'd0);
    chk("t2_no_err", 32'(es2), 32'h0);
    tick();
    chk("t2_rdv_unexpected", 32'(ep2), 32'h10);
    chk("t2_pending_stays0", 32'(pd2), 32'd0);
    if2.readdatavalid = 1'b0;
    tick();
    chk("t2_pulse_once", 32'(ep2), 32'h0);
    if2.read = 1'b1;
    repeat (8) tick();
    chk("t2_pending_max", 32'(pd2), 32'd8);
    chk("t2_at_max_clean", 32'(ep2), 32'h0);
    tick();
    chk("t2_overflow", 32'(ep2), 32'h20);
    chk("t2_pending_sat", 32'(pd2), 32'd8);
    if2.read = 1'b0; if2.readdatavalid = 1'b1;
    repeat (8) tick();
    chk("t2_drained", 32'(pd2), 32'd0);
    if2.readdatavalid = 1'b0;
    tick();

    // T3 mode 3: data on time, then one cycle late
    if3.read = 1'b1;
    tick();
    if3.read = 1'b0;
    tick();
    if3.readdatavalid = 1'b1;
    tick();
    chk("t3_on_time_clean", 32'(ep3), 32'h0);
    chk("t3_pending0", 32'(pd3), 32'd0);
    if3.readdatavalid = 1'b0;
    tick();
    if3.read = 1'b1;
    tick();
    if3.read = 1'b0;
    tick();
    tick();
    chk("t3_missing_rdv", 32'(ep3), 32'h40);
    if3.readdatavalid = 1'b1;
    tick();
    chk("t3_late_rdv", 32'(ep3), 32'h40);
    if3.readdatavalid = 1'b0;
    tick();
    chk("t3_quiet_after", 32'(ep3), 32'h0);

    // T4 mode 4: clean 4-beat write burst
    if4.write = 1'b1; if4.burstcount = 8'd4; if4.address = 8'h20; if4.beginbursttransfer = 1'b1;
    tick();
    if4.beginbursttransfer = 1'b0;
    repeat (3) tick();
    if4.write = 1'b0;
    tick();
    chk("t4_clean_burst", 32'(es4), 32'h0);
    // address changes on beat 3
    if4.write = 1'b1; if4.beginbursttransfer = 1'b1;
    tick();
    if4.beginbursttransfer = 1'b0;
    tick();
    if4.address = 8'h24;
    tick();
    chk("t4_burst_addr", 32'(ep4), 32'h80);
    chk("t4_first_err", 32'(fe4), 32'(ERR_BURST_ADDR));
    if4.address = 8'h20;
    tick();
    chk("t4_beat4_clean", 32'(ep4), 32'h0);
    if4.write = 1'b0;
    tick();
    // read in the middle of a burst
    if4.write = 1'b1; if4.beginbursttransfer = 1'b1;
    tick();
    if4.write = 1'b0; if4.beginbursttransfer = 1'b0; if4.read = 1'b1;
    tick();
    chk("t4_interleave", 32'(ep4), 32'h100);
    chk("t4_interleave_pending", 32'(pd4), 32'd4);
    if4.read = 1'b0; if4.write = 1'b1;
    repeat (3) tick();
    chk("t4_burst_resumed_clean", 32'(ep4), 32'h0);
    if4.write = 1'b0; if4.readdatavalid = 1'b1;
    repeat (4) tick();
    chk("t4_drained", 32'(pd4), 32'd0);
    if4.readdatavalid = 1'b0;
    tick();

    // T5 mode 4: read burst of 8, then read and write together, then burstcount zero
    if4.read = 1'b1; if4.burstcount = 8'd8; if4.beginbursttransfer = 1'b1;
    tick();
    chk("t5_pending8", 32'(pd4), 32'd8);
    chk("t5_read_burst_clean", 32'(ep4), 32'h0);
    if4.read = 1'b0; if4.beginbursttransfer = 1'b0; if4.readdatavalid = 1'b1;
    repeat (8) tick();
    chk("t5_pending_back0", 32'(pd4), 32'd0);
    if4.readdatavalid = 1'b0;
    if4.read = 1'b1; if4.write = 1'b1; if4.burstcount = 8'd1; if4.beginbursttransfer = 1'b1;
    tick();
    chk("t5_rw_both", 32'(ep4), 32'h2);
    chk("t5_rw_pending1", 32'(pd4), 32'd1);
    if4.read = 1'b0; if4.write = 1'b0; if4.beginbursttransfer = 1'b0; if4.readdatavalid = 1'b1;
    tick();
    if4.readdatavalid = 1'b0;
    if4.write = 1'b1; if4.burstcount = 8'd0; if4.beginbursttransfer = 1'b1;
    tick();
    chk("t5_burstcount_zero", 32'(ep4), 32'h200);
    if4.write = 1'b0; if4.burstcount = 8'd1; if4.beginbursttransfer = 1'b0;
    tick();

    // T6: clear, clear beating a same-cycle error, then asynchronous reset mid-burst
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear_sticky", 32'(es4), 32'h0);
    chk("t6_clear_first_err", 32'(fe4), 32'(ERR_NONE));
    if0.read = 1'b1; if0.write = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear_wins_sticky", 32'(es0), 32'h0);
    chk("t6_clear_wins_first", 32'(fe0), 32'(ERR_NONE));
    tick();
    chk("t6_relatch_first", 32'(fe0), 32'(ERR_RW_BOTH));
    chk("t6_relatch_cycle", fc0, 32'(tcyc));
    if0.read = 1'b0; if0.write = 1'b0;
    tick();
    if4.read = 1'b1; if4.burstcount = 8'd3; if4.beginbursttransfer = 1'b1;
    tick();
    chk("t6_pending3", 32'(pd4), 32'd3);
    if4.read = 1'b0; if4.write = 1'b1; if4.burstcount = 8'd4; if4.address = 8'h40;
    tick();
    if4.beginbursttransfer = 1'b0; if4.address = 8'h44;
    tick();
    chk("t6_pre_reset_err", 32'(ep4), 32'h80);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_pulse", 32'(ep4), 32'h0);
    chk("t6_rst_sticky", 32'(es4), 32'h0);
    chk("t6_rst_first_err", 32'(fe4), 32'(ERR_NONE));
    chk("t6_rst_first_cycle", fc4, 32'h0);
    chk("t6_rst_pending", 32'(pd4), 32'd0);
    if4.write = 1'b0; if4.address = 8'h40;
    rst  = 1'b0;
    tcyc = 0;
    if4.write = 1'b1; if4.burstcount = 8'd1; if4.beginbursttransfer = 1'b1;
    tick();
    chk("t6_fsm_idle_after_rst", 32'(ep4), 32'h0);
    if4.write = 1'b0; if4.beginbursttransfer = 1'b0;
    tick();
    chk("t6_first_err_still_none", 32'(fe4), 32'(ERR_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
